// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC/nPC sequencing controller: FSM state encoding
// and instruction size.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_TRAP = 2'd2,
    S_HALT = 2'd3
  } state_t;

  localparam int unsigned INSN_BYTES = 4;

endpackage

// File: rtl/pc_seq_ctrl.sv
// PC/nPC sequencing controller: computes next pc/npc values and load enables
// for boot wait, stalls, delayed branches with annul, trap redirect and halt.
module pc_seq_ctrl
  import pc_seq_pkg::*;
#(
  parameter int unsigned BOOT_CYCLES = 2,
  parameter int unsigned TRAP_FLUSH  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_q,
  input  logic [31:0] npc_q,
  input  logic        stall,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic        br_always,
  input  logic        br_annul,
  input  logic [31:0] br_target,
  input  logic        trap_req,
  input  logic [31:0] trap_vec,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] pc_d,
  output logic [31:0] npc_d,
  output logic        pc_le,
  output logic        npc_le,
  output logic        fetch_valid,
  output logic        delay_squash,
  output logic [1:0]  state
);

  localparam logic [31:0] STEP      = 32'(INSN_BYTES);
  localparam logic [3:0]  BOOT_INIT = 4'(BOOT_CYCLES - 1);
  localparam logic [3:0]  TRAP_INIT = 4'(TRAP_FLUSH - 1);

  state_t     st;
  logic [3:0] cnt;
  logic       sq;
  logic       redirect;
  logic       advance;
  logic       le;

  // pc_q is sequenced by the external registers; only npc_q feeds the next-address mux.
  logic unused;
  assign unused = ^pc_q;

  assign redirect = trap_req & ((st == S_RUN) | (st == S_HALT));
  assign advance  = (st == S_RUN) & ~trap_req & ~halt_req & ~stall;

  always_comb begin
    pc_d  = npc_q;
    npc_d = npc_q + STEP;
    le    = 1'b0;
    if (redirect) begin
      pc_d  = trap_vec;
      npc_d = trap_vec + STEP;
      le    = 1'b1;
    end else if (advance) begin
      le = 1'b1;
      if (br_valid & br_taken) npc_d = br_target;
    end
  end

  assign pc_le        = le;
  assign npc_le       = le;
  assign fetch_valid  = (st == S_RUN) & ~sq;
  assign delay_squash = (st == S_RUN) & sq;
  assign state        = st;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st  <= S_BOOT;
      cnt <= BOOT_INIT;
      sq  <= 1'b0;
    end else begin
      case (st)
        S_BOOT, S_TRAP: begin
          if (cnt == 4'd0) st <= S_RUN;
          else             cnt <= cnt - 4'd1;
        end
        S_RUN: begin
          if (trap_req) begin
            st  <= S_TRAP;
            cnt <= TRAP_INIT;
            sq  <= 1'b0;
          end else if (halt_req) begin
            st <= S_HALT;
          end else if (!stall) begin
            // Annul drops the slot for untaken branches and for BA, never for taken conditionals.
            sq <= br_valid & br_annul & (~br_taken | br_always);
          end
        end
        S_HALT: begin
          if (trap_req) begin
            st  <= S_TRAP;
            cnt <= TRAP_INIT;
            sq  <= 1'b0;
          end else if (resume) begin
            st <= S_RUN;
          end
        end
        default: st <= S_BOOT;
      endcase
    end
  end

endmodule
